fport_uart_rx: RTL and testbench

FPORT_UART_RX -- requirements
Module: fport_uart_rx

---
 rtl/fport_uart_rx_pkg.sv | 24 ++
 rtl/fport_uart_rx_sync.sv | 28 ++
 rtl/fport_uart_rx.sv | 151 +++++++++++++++
 tb/tb_fport_uart_rx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fport_uart_rx_pkg.sv
// Shared definitions for the F.Port UART receiver: state encoding, bit timing
// helpers and the default F.Port line rate.
package fport_pkg;

  localparam int FPORT_BAUD = 115200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Rounded clocks per bit.
  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int calc_half_cycles(input int clk_freq, input int baud);
    return calc_bit_cycles(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/fport_uart_rx_sync.sv
// Two-flop synchronizer with a configurable asynchronous reset value so the
// line can come out of reset already at its idle level.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fport_uart_rx.sv
// 8N1 UART receiver for the F.Port link: synchronized, optionally inverted
// input, majority-voted bits, framing-error and idle-line detection.
module fport_uart_rx
  import fport_pkg::*;
#(
  parameter int CLK_FREQ  = 16000000,
  parameter int BAUD      = FPORT_BAUD,
  parameter bit INVERT    = 1'b1,
  parameter int IDLE_BITS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxPin,
  output logic [7:0] rxData,
  output logic       rxDataAvail,
  output logic       frameError,
  output logic       rxIdle
);

  localparam int BIT_CYCLES  = calc_bit_cycles(CLK_FREQ, BAUD);
  localparam int HALF_CYCLES = calc_half_cycles(CLK_FREQ, BAUD);
  localparam int IDLE_MAX    = IDLE_BITS * BIT_CYCLES;
  localparam int CNT_W       = $clog2(BIT_CYCLES) + 1;
  localparam int IDLE_W      = $clog2(IDLE_MAX) + 1;

  localparam logic [CNT_W-1:0]  C_HALF_M1  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_BIT_M1   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_BIT_M2   = CNT_W'(BIT_CYCLES - 2);
  localparam logic [IDLE_W-1:0] C_IDLE_MAX = IDLE_W'(IDLE_MAX);
  localparam logic              PIN_IDLE   = ~INVERT;

  rx_state_e         r_state;
  rx_state_e         w_nextState;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;
  logic [7:0]        r_rxData;
  logic              r_v0;
  logic              r_v1;
  logic              r_voteDue;
  logic              r_rxDataAvail;
  logic              r_frameError;
  logic [IDLE_W-1:0] r_idleCnt;

  logic w_pinSync;
  logic w_line;
  logic w_vote;
  logic w_midStart;
  logic w_inBit;
  logic w_cntClr;
  logic w_bitWrap;
  logic w_capV0;
  logic w_shiftEn;
  logic w_loadData;
  logic w_frameErr;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (PIN_IDLE)
  ) u_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (rxPin),
    .o_q   (w_pinSync)
  );

  assign w_line     = w_pinSync ^ INVERT;
  assign w_vote     = (r_v0 & r_v1) | (r_v0 & w_line) | (r_v1 & w_line);
  assign w_midStart = (r_state == ST_START) && (r_bitCnt == C_HALF_M1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:      if (!w_line) w_nextState = ST_START;
      ST_START:     if (w_midStart) w_nextState = w_line ? ST_IDLE : ST_DATA;
      ST_DATA:      if (r_voteDue && (r_bitIdx == 3'd7)) w_nextState = ST_STOP;
      ST_STOP:      if (r_voteDue) w_nextState = w_vote ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (w_line) w_nextState = ST_IDLE;
      default:      w_nextState = ST_IDLE;
    endcase
  end

  // The vote is resolved on the cycle after the counter wraps, using the
  // two stored samples plus the live line value.
  always_comb begin
    w_inBit    = (r_state == ST_DATA) || (r_state == ST_STOP);
    w_cntClr   = (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH) || w_midStart;
    w_bitWrap  = w_inBit && (r_bitCnt == C_BIT_M1);
    w_capV0    = w_inBit && (r_bitCnt == C_BIT_M2);
    w_shiftEn  = (r_state == ST_DATA) && r_voteDue;
    w_loadData = (r_state == ST_STOP) && r_voteDue && w_vote;
    w_frameErr = (r_state == ST_STOP) && r_voteDue && !w_vote;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bitCnt      <= '0;
      r_bitIdx      <= '0;
      r_shift       <= '0;
      r_rxData      <= '0;
      r_v0          <= 1'b0;
      r_v1          <= 1'b0;
      r_voteDue     <= 1'b0;
      r_rxDataAvail <= 1'b0;
      r_frameError  <= 1'b0;
    end else begin
      if (w_cntClr || w_bitWrap) begin
        r_bitCnt <= '0;
      end else begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
      r_voteDue <= w_bitWrap;
      if (w_capV0) r_v0 <= w_line;
      if (w_bitWrap) r_v1 <= w_line;
      if (w_midStart) begin
        r_bitIdx <= '0;
      end else if (w_shiftEn && (r_bitIdx != 3'd7)) begin
        r_bitIdx <= r_bitIdx + 1'b1;
      end
      if (w_shiftEn) r_shift <= {w_vote, r_shift[7:1]};
      if (w_loadData) r_rxData <= r_shift;
      r_rxDataAvail <= w_loadData;
      r_frameError  <= w_frameErr;
    end
  end

  // Any low line clears the idle count, so a start bit beats saturation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idleCnt <= '0;
    end else if (!w_line) begin
      r_idleCnt <= '0;
    end else if ((r_state == ST_IDLE) && (r_idleCnt != C_IDLE_MAX)) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  assign rxData      = r_rxData;
  assign rxDataAvail = r_rxDataAvail;
  assign frameError  = r_frameError;
  assign rxIdle      = (r_idleCnt == C_IDLE_MAX);

endmodule

// File: tb/tb_fport_uart_rx.sv
// Bench for fport_uart_rx at default parameters (16 MHz, 115200 baud, inverted pin).
module tb_fport_uart_rx;

  localparam int BITC = 139;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxPin = 1'b0;
  logic [7:0] rxData;
  logic       rxDataAvail;
  logic       frameError;
  logic       rxIdle;

  int n_checks = 0;
  int n_fail   = 0;
  int avail_cnt = 0;
  int fe_cnt    = 0;
  int both_cnt  = 0;
  int long_cnt  = 0;
  logic prev_avail = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  fport_uart_rx dut (
    .clock       (clock),
    .reset       (reset),
    .rxPin       (rxPin),
    .rxData      (rxData),
    .rxDataAvail (rxDataAvail),
    .frameError  (frameError),
    .rxIdle      (rxIdle)
  );

  always #5 clock = ~clock;

  always begin
    @(posedge clock);
    #2;
    if (rxDataAvail) begin
      got_q.push_back(rxData);
      avail_cnt++;
      if (prev_avail) long_cnt++;
    end
    if (frameError) fe_cnt++;
    if (rxDataAvail && frameError) both_cnt++;
    prev_avail = rxDataAvail;
  end

  // Frame bits are line levels; the pin carries the inverted level.
  task automatic send_frame(input logic [9:0] fr, input int nbits, input int bitc);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      rxPin = ~fr[i];
      repeat (bitc - 1) @(negedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bitc);
    send_frame({1'b1, b, 1'b0}, 10, bitc);
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while ((got_q.size() < n) && (k < budget)) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++;
    if (rxData !== 8'h00) begin n_fail++; $display("FAIL reset_rxData: got %h want 00", rxData); end
    n_checks++;
    if (rxDataAvail !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b want 0", rxDataAvail); end
    n_checks++;
    if (frameError !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frameError); end
    n_checks++;
    if (rxIdle !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", rxIdle); end
    reset = 1'b0;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_single;
    int a0, f0;
    logic [7:0] e, g;
    a0 = avail_cnt; f0 = fe_cnt;
    exp_q.push_back(8'h7E);
    send_frame({1'b1, 8'h7E, 1'b0}, 9, BITC);
    @(negedge clock);
    rxPin = 1'b0;
    repeat (59) @(negedge clock);
    n_checks++;
    if (avail_cnt !== a0) begin n_fail++; $display("FAIL single_early: pulses %0d want %0d", avail_cnt - a0, 0); end
    repeat (80) @(negedge clock);
    n_checks++;
    if (avail_cnt !== a0 + 1) begin n_fail++; $display("FAIL single_count: pulses %0d want 1", avail_cnt - a0); end
    n_checks++;
    if (fe_cnt !== f0) begin n_fail++; $display("FAIL single_ferr: errors %0d want 0", fe_cnt - f0); end
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL single_data: no byte, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", g, e); end
    end
    n_checks++;
    if (rxData !== 8'h7E) begin n_fail++; $display("FAIL single_hold: got %h want 7e", rxData); end
  endtask

  task automatic test_back_to_back;
    int a0, f0;
    logic [7:0] e, g;
    a0 = avail_cnt; f0 = fe_cnt;
    exp_q.push_back(8'h7D);
    exp_q.push_back(8'h5E);
    send_byte(8'h7D, BITC);
    send_byte(8'h5E, BITC);
    rxPin = 1'b0;
    wait_got(2, 600);
    repeat (10) @(negedge clock);
    n_checks++;
    if (avail_cnt !== a0 + 2) begin n_fail++; $display("FAIL b2b_count: pulses %0d want 2", avail_cnt - a0); end
    n_checks++;
    if (fe_cnt !== f0) begin n_fail++; $display("FAIL b2b_ferr: errors %0d want 0", fe_cnt - f0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_data%0d: no byte, want %h", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, g, e); end
      end
    end
    n_checks++;
    if (rxData !== 8'h5E) begin n_fail++; $display("FAIL b2b_hold: got %h want 5e", rxData); end
  endtask

  task automatic test_glitch;
    int a0, f0;
    logic [7:0] e, g;
    a0 = avail_cnt; f0 = fe_cnt;
    @(negedge clock);
    rxPin = 1'b1;
    repeat (40) @(negedge clock);
    rxPin = 1'b0;
    repeat (400) @(negedge clock);
    n_checks++;
    if (avail_cnt !== a0) begin n_fail++; $display("FAIL glitch_avail: pulses %0d want 0", avail_cnt - a0); end
    n_checks++;
    if (fe_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: errors %0d want 0", fe_cnt - f0); end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BITC);
    rxPin = 1'b0;
    wait_got(1, 600);
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL glitch_after: no byte, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL glitch_after: got %h want %h", g, e); end
    end
  endtask

  task automatic test_frame_error;
    int a0, f0;
    logic [7:0] e, g;
    repeat (50) @(negedge clock);
    a0 = avail_cnt; f0 = fe_cnt;
    send_frame({1'b0, 8'hA5, 1'b0}, 10, BITC);
    rxPin = 1'b1;
    repeat (3000) @(negedge clock);
    n_checks++;
    if (fe_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_count: errors %0d want 1", fe_cnt - f0); end
    n_checks++;
    if (avail_cnt !== a0) begin n_fail++; $display("FAIL ferr_avail: pulses %0d want 0", avail_cnt - a0); end
    n_checks++;
    if (rxData !== 8'h3C) begin n_fail++; $display("FAIL ferr_hold: got %h want 3c", rxData); end
    rxPin = 1'b0;
    repeat (300) @(negedge clock);
    n_checks++;
    if (fe_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_release: errors %0d want 1", fe_cnt - f0); end
    exp_q.push_back(8'h81);
    send_byte(8'h81, BITC);
    rxPin = 1'b0;
    wait_got(1, 600);
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL ferr_recover: no byte, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL ferr_recover: got %h want %h", g, e); end
    end
  endtask

  task automatic test_idle;
    int k, m, a0, f0;
    @(negedge clock);
    reset = 1'b1;
    rxPin = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    a0 = avail_cnt; f0 = fe_cnt;
    k = 0;
    while (!rxIdle && (k < 2000)) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if ((k < 1390) || (k > 1392)) begin n_fail++; $display("FAIL idle_rise: cycles %0d want 1390..1392", k); end
    rxPin = 1'b1;
    m = 0;
    while (rxIdle && (m < 20)) begin
      @(negedge clock);
      m++;
    end
    n_checks++;
    if ((m < 2) || (m > 3)) begin n_fail++; $display("FAIL idle_fall: cycles %0d want 2..3", m); end
    rxPin = 1'b0;
    repeat (300) @(negedge clock);
    n_checks++;
    if ((avail_cnt !== a0) || (fe_cnt !== f0)) begin
      n_fail++; $display("FAIL idle_spurious: pulses %0d errors %0d want 0 0", avail_cnt - a0, fe_cnt - f0);
    end
  endtask

  task automatic test_reset_mid;
    int a0, f0;
    logic [7:0] e, g;
    send_frame({1'b1, 8'h55, 1'b0}, 5, BITC);
    @(negedge clock);
    rxPin = 1'b0;
    repeat (60) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (rxData !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", rxData); end
    n_checks++;
    if ((rxDataAvail !== 1'b0) || (frameError !== 1'b0) || (rxIdle !== 1'b0)) begin
      n_fail++; $display("FAIL rstmid_flags: avail %b ferr %b idle %b want 0 0 0", rxDataAvail, frameError, rxIdle);
    end
    rxPin = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    a0 = avail_cnt; f0 = fe_cnt;
    repeat (300) @(negedge clock);
    n_checks++;
    if ((avail_cnt !== a0) || (fe_cnt !== f0)) begin
      n_fail++; $display("FAIL rstmid_partial: pulses %0d errors %0d want 0 0", avail_cnt - a0, fe_cnt - f0);
    end
    exp_q.push_back(8'h19);
    send_byte(8'h19, BITC);
    rxPin = 1'b0;
    wait_got(1, 600);
    repeat (10) @(negedge clock);
    n_checks++;
    if (avail_cnt !== a0 + 1) begin n_fail++; $display("FAIL rstmid_count: pulses %0d want 1", avail_cnt - a0); end
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL rstmid_data2: no byte, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL rstmid_data2: got %h want %h", g, e); end
    end
  endtask

  task automatic test_skew;
    logic [7:0] bytes [4];
    int         bitcs [4];
    logic [7:0] e, g;
    bytes = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    bitcs = '{142, 142, 136, 136};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bytes[i]);
      send_byte(bytes[i], bitcs[i]);
      rxPin = 1'b0;
      repeat (30) @(negedge clock);
    end
    wait_got(4, 600);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL skew_data%0d: no byte, want %h", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL skew_data%0d: got %h want %h", i, g, e); end
      end
    end
  endtask

  task automatic test_final;
    repeat (20) @(negedge clock);
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL both_pulses: cycles %0d want 0", both_cnt); end
    n_checks++;
    if (long_cnt !== 0) begin n_fail++; $display("FAIL pulse_width: long pulses %0d want 0", long_cnt); end
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL extra_bytes: leftover %0d want 0", got_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_idle;
    test_reset_mid;
    test_skew;
    test_final;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
